simple_phase_sequencer: RTL and testbench

SIMPLE_PHASE_SEQUENCER -- requirements
Module: simple_phase_sequencer

---
 rtl/simple_pkg.sv | 40 ++++
 rtl/btn_pulse.sv | 28 ++
 rtl/simple_phase_sequencer.sv | 165 ++++++++++++++++
 tb/tb_simple_phase_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared definitions for the simple phase sequencer: FSM states, phase codes
// and phase_en bit positions.
package simple_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_MEM_WAIT,
        ST_STEP_WAIT,
        ST_HALTED
    } state_e;

    localparam logic [2:0] PH_NONE = 3'd0;
    localparam logic [2:0] PH_P1   = 3'd1;
    localparam logic [2:0] PH_P2   = 3'd2;
    localparam logic [2:0] PH_P3   = 3'd3;
    localparam logic [2:0] PH_P4   = 3'd4;
    localparam logic [2:0] PH_P5   = 3'd5;

    localparam int unsigned EN_P1 = 0;
    localparam int unsigned EN_P2 = 1;
    localparam int unsigned EN_P3 = 2;
    localparam int unsigned EN_P4 = 3;
    localparam int unsigned EN_P5 = 4;

    function automatic logic [4:0] phase_onehot(input logic [2:0] ph);
        logic [4:0] oh;
        oh = '0;
        case (ph)
            PH_P1:   oh[EN_P1] = 1'b1;
            PH_P2:   oh[EN_P2] = 1'b1;
            PH_P3:   oh[EN_P3] = 1'b1;
            PH_P4:   oh[EN_P4] = 1'b1;
            PH_P5:   oh[EN_P5] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioning: two-flop synchroniser followed by a rising-edge detector
// producing a single-cycle pulse.
module btn_pulse (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/simple_phase_sequencer.sv
// Five-phase instruction sequencer with memory wait/timeout, latched stop and
// optional single-step mode (enabled by defining SIMPLE_STEP_EN).
module simple_phase_sequencer
    import simple_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_btn,
    input  logic             stop_btn,
    input  logic             step_btn,
    input  logic             step_mode,
    input  logic             halt_instr,
    input  logic             mem_access,
    input  logic             mem_ack,
    output logic [2:0]       phase,
    output logic [4:0]       phase_en,
    output logic             mem_req,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    logic run_p, stop_p, step_p, step_go;

    btn_pulse u_run  (.clk_i(clock), .rst_ni(reset), .btn_i(run_btn),  .pulse_o(run_p));
    btn_pulse u_stop (.clk_i(clock), .rst_ni(reset), .btn_i(stop_btn), .pulse_o(stop_p));
    btn_pulse u_step (.clk_i(clock), .rst_ni(reset), .btn_i(step_btn), .pulse_o(step_p));

`ifdef SIMPLE_STEP_EN
    assign step_go = step_mode;
`else
    logic unused_step;
    assign step_go     = 1'b0;
    assign unused_step = step_mode ^ step_p;
`endif

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic             stop_q, stop_d;
    logic             fault_q, fault_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            stop_q  <= 1'b0;
            fault_q <= 1'b0;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            stop_q  <= stop_d;
            fault_q <= fault_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        stop_d     = stop_q;
        fault_d    = fault_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        phase      = PH_NONE;
        phase_en   = '0;
        mem_req    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (run_p) begin
                    state_d = ST_RUN;
                    phase_d = PH_P1;
                    fault_d = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            ST_RUN: begin
                phase    = phase_q;
                phase_en = phase_onehot(phase_q);
                if (stop_p) stop_d = 1'b1;
                case (phase_q)
                    // mem_access is sampled on the edge into P4, so the wait
                    // state is already active during the first P4 cycle.
                    PH_P3: begin
                        phase_d = PH_P4;
                        if (mem_access) begin
                            state_d = ST_MEM_WAIT;
                            tmr_d   = '0;
                        end
                    end
                    PH_P5: begin
                        instr_done = 1'b1;
                        cnt_d      = cnt_q + CNT_W'(1);
                        stop_d     = 1'b0;
                        phase_d    = PH_P1;
                        if (halt_instr) begin
                            state_d = ST_HALTED;
                            phase_d = PH_NONE;
                        end else if (stop_q || stop_p) begin
                            state_d = ST_IDLE;
                            phase_d = PH_NONE;
                        end else if (step_go) begin
                            state_d = ST_STEP_WAIT;
                            phase_d = PH_NONE;
                        end
                    end
                    default: phase_d = phase_q + 3'd1;
                endcase
            end
            ST_MEM_WAIT: begin
                phase   = PH_P4;
                mem_req = 1'b1;
                if (stop_p) stop_d = 1'b1;
                if (mem_ack) begin
                    phase_en[EN_P4] = 1'b1;
                    state_d         = ST_RUN;
                    phase_d         = PH_P5;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_HALTED;
                    phase_d = PH_NONE;
                    fault_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STEP_WAIT: begin
`ifdef SIMPLE_STEP_EN
                if (stop_p) begin
                    state_d = ST_IDLE;
                end else if (step_p || (run_p && !step_mode)) begin
                    state_d = ST_RUN;
                    phase_d = PH_P1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_NONE;
            end
        endcase
    end

    assign running     = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT) ||
                         (state_q == ST_STEP_WAIT);
    assign halted      = (state_q == ST_HALTED);
    assign fault       = fault_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_simple_phase_sequencer.sv
// Self-checking bench for simple_phase_sequencer: directed scenarios plus a
// randomized instruction stream checked against a per-instruction timeline model.
module tb_simple_phase_sequencer;

    localparam int unsigned CW  = 8;
    localparam int unsigned TMO = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          run_btn = 1'b0, stop_btn = 1'b0, step_btn = 1'b0, step_mode = 1'b0;
    logic          halt_instr = 1'b0, mem_access = 1'b0, mem_ack = 1'b0;
    logic [2:0]    phase;
    logic [4:0]    phase_en;
    logic          mem_req, running, halted, fault, instr_done;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    simple_phase_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .run_btn(run_btn), .stop_btn(stop_btn),
        .step_btn(step_btn), .step_mode(step_mode), .halt_instr(halt_instr),
        .mem_access(mem_access), .mem_ack(mem_ack), .phase(phase), .phase_en(phase_en),
        .mem_req(mem_req), .running(running), .halted(halted), .fault(fault),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise a button and hold it until the FSM has acted on the resulting pulse.
    task automatic press(input int which);
        if (which == 0) run_btn = 1'b1;
        else if (which == 1) stop_btn = 1'b1;
        else step_btn = 1'b1;
        repeat (3) tick();
        run_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        reset = 1'b0;
        #3;
        got = {phase, phase_en, mem_req, running, halted, fault, instr_done, instr_count};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", got);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        tick(); tick();
        got = {phase, phase_en, mem_req, running, halted, fault, instr_done, instr_count};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL idle_after_reset got=%h want=0", got);
        end
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        logic [9:0] got, want;
        press(0);
        for (int c = 0; c < 5; c++) begin
            got  = {phase, phase_en, mem_req, instr_done};
            want = {3'(c + 1), 5'(1 << c), 1'b0, (c == 4)};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL basic_cycle%0d got=%h want=%h", c, got, want);
            end
            tick();
        end
        exp_cnt++;
        total++;
        if ({phase, instr_count} !== {3'd1, CW'(exp_cnt)}) begin
            bad++; $display("FAIL basic_wrap_p1 got=%0d/%0d want=1/%0d", phase, instr_count, exp_cnt);
        end
        halt_instr = 1'b1;
        repeat (5) tick();
        halt_instr = 1'b0;
        exp_cnt++;
        total++;
        if ({phase, running, halted, fault, instr_count} !== {3'd0, 3'b010, CW'(exp_cnt)}) begin
            bad++; $display("FAIL basic_halt got ph=%0d run=%b hlt=%b flt=%b cnt=%0d want 0/0/1/0/%0d",
                            phase, running, halted, fault, instr_count, exp_cnt);
        end
    endtask

    task automatic test_mem_ack();
        logic [8:0] got, want;
        press(0);
        mem_access = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3);
            #1;
            got  = {phase, phase_en, mem_req};
            want = {3'd4, (k == 3) ? 5'b01000 : 5'b00000, 1'b1};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL memack_wait%0d got=%h want=%h", k, got, want);
            end
            tick();
        end
        mem_ack = 1'b0;
        mem_access = 1'b0;
        got  = {phase, phase_en, mem_req};
        want = {3'd5, 5'b10000, 1'b0};
        total++;
        if (got !== want || instr_done !== 1'b1) begin
            bad++; $display("FAIL memack_p5 got=%h done=%b want=%h done=1", got, instr_done, want);
        end
        halt_instr = 1'b1;
        tick();
        halt_instr = 1'b0;
        exp_cnt++;
        total++;
        if ({halted, instr_count} !== {1'b1, CW'(exp_cnt)}) begin
            bad++; $display("FAIL memack_halt got=%b/%0d want=1/%0d", halted, instr_count, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [12:0] got, want;
        press(0);
        mem_access = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < int'(TMO); k++) begin
            total++;
            if ({phase, mem_req, phase_en} !== {3'd4, 1'b1, 5'b0}) begin
                bad++; $display("FAIL timeout_wait%0d got ph=%0d req=%b en=%b", k, phase, mem_req, phase_en);
            end
            tick();
        end
        mem_access = 1'b0;
        got  = {phase, phase_en, mem_req, running, halted, fault, instr_count};
        want = {3'd0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1, CW'(exp_cnt)};
        total++;
        if (got[12:0] !== want[12:0] || instr_count !== CW'(exp_cnt)) begin
            bad++; $display("FAIL timeout_fault got ph=%0d req=%b run=%b hlt=%b flt=%b cnt=%0d want 0/0/0/1/1/%0d",
                            phase, mem_req, running, halted, fault, instr_count, exp_cnt);
        end
        press(0);
        total++;
        if ({phase, fault, halted} !== {3'd1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL timeout_restart got ph=%0d flt=%b hlt=%b want 1/0/0", phase, fault, halted);
        end
        halt_instr = 1'b1;
        repeat (5) tick();
        halt_instr = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_stop_halt();
        press(0);
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        halt_instr = 1'b1;
        repeat (4) tick();
        halt_instr = 1'b0;
        exp_cnt++;
        total++;
        if ({halted, running, phase} !== {1'b1, 1'b0, 3'd0}) begin
            bad++; $display("FAIL stop_vs_halt got hlt=%b run=%b ph=%0d want 1/0/0", halted, running, phase);
        end
        press(0);
        total++;
        if (phase !== 3'd1) begin
            bad++; $display("FAIL stop_restart got ph=%0d want 1", phase);
        end
        repeat (5) tick();
        exp_cnt++;
        total++;
        if ({phase, running} !== {3'd1, 1'b1}) begin
            bad++; $display("FAIL stop_cleared got ph=%0d run=%b want 1/1", phase, running);
        end
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        repeat (4) tick();
        exp_cnt++;
        total++;
        if ({phase, running, halted, instr_count} !== {3'd0, 1'b0, 1'b0, CW'(exp_cnt)}) begin
            bad++; $display("FAIL stop_to_idle got ph=%0d run=%b hlt=%b cnt=%0d want 0/0/0/%0d",
                            phase, running, halted, instr_count, exp_cnt);
        end
    endtask

    task automatic test_step();
        step_mode = 1'b1;
        press(0);
        repeat (5) tick();
        exp_cnt++;
`ifdef SIMPLE_STEP_EN
        total++;
        if ({phase, running, instr_count} !== {3'd0, 1'b1, CW'(exp_cnt)}) begin
            bad++; $display("FAIL step_pause got ph=%0d run=%b cnt=%0d want 0/1/%0d", phase, running, instr_count, exp_cnt);
        end
        repeat (3) tick();
        total++;
        if (phase !== 3'd0) begin
            bad++; $display("FAIL step_hold got ph=%0d want 0", phase);
        end
        press(2);
        total++;
        if (phase !== 3'd1) begin
            bad++; $display("FAIL step_resume got ph=%0d want 1", phase);
        end
        repeat (5) tick();
        exp_cnt++;
        total++;
        if ({phase, running, instr_count} !== {3'd0, 1'b1, CW'(exp_cnt)}) begin
            bad++; $display("FAIL step_one_more got ph=%0d run=%b cnt=%0d want 0/1/%0d", phase, running, instr_count, exp_cnt);
        end
        press(1);
        total++;
        if ({phase, running} !== {3'd0, 1'b0}) begin
            bad++; $display("FAIL step_stop got ph=%0d run=%b want 0/0", phase, running);
        end
`else
        total++;
        if ({phase, running, instr_count} !== {3'd1, 1'b1, CW'(exp_cnt)}) begin
            bad++; $display("FAIL step_ignored got ph=%0d run=%b cnt=%0d want 1/1/%0d", phase, running, instr_count, exp_cnt);
        end
        press(2);
        halt_instr = 1'b1;
        repeat (2) tick();
        halt_instr = 1'b0;
        exp_cnt++;
        total++;
        if ({halted, instr_count} !== {1'b1, CW'(exp_cnt)}) begin
            bad++; $display("FAIL step_btn_ignored got hlt=%b cnt=%0d want 1/%0d", halted, instr_count, exp_cnt);
        end
`endif
        step_mode = 1'b0;
    endtask

    // Each instruction is modelled as a timeline: P1..P3, then either one P4
    // cycle or (latency+1) wait cycles, then P5, unless the wait hits the limit.
    task automatic test_random();
        logic [9:0] got, want;
        int lat, kmax;
        bit m, h, to;
        press(0);
        for (int i = 0; i < 60; i++) begin
            m   = (i != 59) && ($urandom_range(0, 1) == 1);
            lat = $urandom_range(0, 17);
            h   = (i == 59) || ($urandom_range(0, 7) == 0);
            to  = m && (lat >= int'(TMO));
            mem_access = m;
            halt_instr = h;
`ifndef SIMPLE_STEP_EN
            step_mode  = $urandom_range(0, 1);
            step_btn   = $urandom_range(0, 1);
`endif
            for (int c = 1; c <= 3; c++) begin
                mem_ack = $urandom_range(0, 1);
                #1;
                got  = {phase, phase_en, mem_req, instr_done};
                want = {3'(c), 5'(1 << (c - 1)), 1'b0, 1'b0};
                total++;
                if (got !== want) begin
                    bad++; $display("FAIL rnd%0d_p%0d got=%h want=%h", i, c, got, want);
                end
                tick();
            end
            if (m) begin
                kmax = to ? int'(TMO) - 1 : lat;
                for (int k = 0; k <= kmax; k++) begin
                    mem_ack = !to && (k == lat);
                    #1;
                    got  = {phase, phase_en, mem_req, instr_done};
                    want = {3'd4, mem_ack ? 5'b01000 : 5'b0, 1'b1, 1'b0};
                    total++;
                    if (got !== want) begin
                        bad++; $display("FAIL rnd%0d_wait%0d got=%h want=%h", i, k, got, want);
                    end
                    tick();
                end
            end else begin
                mem_ack = $urandom_range(0, 1);
                #1;
                got  = {phase, phase_en, mem_req, instr_done};
                want = {3'd4, 5'b01000, 1'b0, 1'b0};
                total++;
                if (got !== want) begin
                    bad++; $display("FAIL rnd%0d_p4 got=%h want=%h", i, got, want);
                end
                tick();
            end
            mem_ack = 1'b0;
            if (to) begin
                total++;
                if ({phase, mem_req, halted, fault, instr_count} !== {3'd0, 1'b0, 1'b1, 1'b1, CW'(exp_cnt)}) begin
                    bad++; $display("FAIL rnd%0d_timeout got ph=%0d req=%b hlt=%b flt=%b cnt=%0d want 0/0/1/1/%0d",
                                    i, phase, mem_req, halted, fault, instr_count, exp_cnt);
                end
                press(0);
                continue;
            end
            mem_ack = $urandom_range(0, 1);
            #1;
            got  = {phase, phase_en, mem_req, instr_done};
            want = {3'd5, 5'b10000, 1'b0, 1'b1};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL rnd%0d_p5 got=%h want=%h", i, got, want);
            end
            tick();
            mem_ack = 1'b0;
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            total++;
            if ({instr_count, halted} !== {CW'(exp_cnt), h}) begin
                bad++; $display("FAIL rnd%0d_after got cnt=%0d hlt=%b want %0d/%b", i, instr_count, halted, exp_cnt, h);
            end
            if (h && i < 59) press(0);
        end
        halt_instr = 1'b0;
        step_btn   = 1'b0;
        step_mode  = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        logic [16:0] got;
        press(0);
        while (exp_cnt != (1 << CW) - 1) begin
            repeat (5) tick();
            exp_cnt++;
        end
        total++;
        if (instr_count !== CW'(exp_cnt)) begin
            bad++; $display("FAIL wrap_pre got=%0d want=%0d", instr_count, exp_cnt);
        end
        repeat (4) tick();
        total++;
        if (instr_done !== 1'b1) begin
            bad++; $display("FAIL wrap_done got=%b want=1", instr_done);
        end
        tick();
        exp_cnt = 0;
        total++;
        if (instr_count !== '0) begin
            bad++; $display("FAIL wrap_zero got=%0d want=0", instr_count);
        end
        mem_access = 1'b1;
        repeat (4) tick();
        total++;
        if (mem_req !== 1'b1) begin
            bad++; $display("FAIL rst_pre_req got=%b want=1", mem_req);
        end
        #2 reset = 1'b0;
        #1;
        got = {phase, phase_en, mem_req, running, halted, fault, instr_done, instr_count};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL rst_mid_wait got=%h want=0", got);
        end
        mem_access = 1'b0;
        @(negedge clock) reset = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        got = {phase, phase_en, mem_req, running, halted, fault, instr_done, instr_count};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL rst_late_ack got=%h want=0", got);
        end
        reset = 1'b0;
        run_btn = 1'b1;
        repeat (2) tick();
        @(negedge clock) reset = 1'b1;
        tick();
        total++;
        if ({phase, running} !== {3'd0, 1'b0}) begin
            bad++; $display("FAIL rst_held_btn got ph=%0d run=%b want 0/0", phase, running);
        end
        run_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mem_ack();
        test_timeout();
        test_stop_halt();
        test_step();
        test_random();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
